// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg: state encoding, frame widths and length rule shared by the loader.
package imem_program_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    // The full 16-bit length is range-checked so a large high byte can never alias a legal size.
    function automatic logic len_bad(input logic [LEN_W-1:0] len, input int unsigned max_bytes);
        return (len == '0) || (len > LEN_W'(max_bytes)) || (len[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte-stream loader that writes a program image into instruction memory
// and holds the core until a checksum-valid image has landed.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int MEM_BYTES = 36,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = $clog2(MEM_BYTES + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_full;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] csum_q, csum_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              accept, last_byte;

    assign rx_ready  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_q[7:0]};
    assign last_byte = (LEN_W'(cnt_q) + LEN_W'(1)) == len_q;

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = state_q != S_DONE;
    assign load_done = state_q == S_DONE;
    assign load_err  = state_q == S_ERR;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                len_d   = {8'h00, rx_data};
                state_d = S_LEN_HI;
            end
            S_LEN_HI: if (accept) begin
                len_d   = len_full;
                cnt_d   = '0;
                csum_d  = '0;
                state_d = len_bad(len_full, MEM_BYTES) ? S_ERR : S_DATA;
            end
            S_DATA: if (accept) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(cnt_q);
                wdata_d = rx_data;
                cnt_d   = cnt_q + CNT_W'(1);
                csum_d  = csum_q ^ rx_data;
                state_d = last_byte ? S_CHK : S_DATA;
            end
            S_CHK: if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            S_DONE, S_ERR: if (start) state_d = S_LEN_LO;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
